// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm bank: per-channel time/enable registers, minute-boundary
// trigger, ring/snooze/auto-stop state machine and a single gated tone output.

package alarm_bank_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} chan_st_e;

  // Setting keys already qualified by channel select
  typedef struct packed {
    logic set_hr;
    logic set_min;
    logic en;
  } set_req_t;

  // Per-channel status back to the bank
  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic       en;
    logic       ring;
  } chan_rsp_t;

  // BCD increment with wrap to 00 at max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)              return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return v + 8'd1;
  endfunction
endpackage

// One alarm channel: time, enable, state and its counters
module alarm_chan
  import alarm_bank_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CP,
  input  logic       nCR,
  input  set_req_t   req_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  input  logic       tick_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] minute_i,
  input  logic [7:0] second_i,
  output chan_rsp_t  rsp_o
);
  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int RW       = $clog2(RING_SEC + 1);
  localparam int CW       = $clog2(SNZ_LOAD + 1);

  logic [7:0]    hr_q, hr_d, mn_q, mn_d;
  logic          en_q, en_d;
  chan_st_e      st_q, st_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [CW-1:0] cd_q, cd_d;
  logic [2:0]    snz_q, snz_d;
  logic          dis, trig, clr;

  // Next-state: setting, trigger detect and ring/snooze FSM
  always_comb begin
    hr_d   = req_i.set_hr  ? bcd_inc(hr_q, 8'h23) : hr_q;
    mn_d   = req_i.set_min ? bcd_inc(mn_q, 8'h59) : mn_q;
    en_d   = en_q ^ req_i.en;
    dis    = req_i.en & en_q;
    // Seconds == 00 makes each match fire only once per minute boundary
    trig   = tick_i & (second_i == 8'h00) & en_q & ~dis &
             (hour_i == hr_q) & (minute_i == mn_q);
    st_d   = st_q;
    ring_d = ring_q;
    cd_d   = cd_q;
    snz_d  = snz_q;
    clr    = 1'b0;
    case (st_q)
      IDLE: begin
        // Stop/snooze have nothing to act on here, so a trigger still lands
        if (trig) begin
          st_d   = RINGING;
          ring_d = '0;
          snz_d  = '0;
        end else if (dis) begin
          clr = 1'b1;
        end
      end
      RINGING: begin
        if (stop_i) begin
          clr = 1'b1;
        end else if (snooze_i) begin
          if (snz_q < 3'(MAX_SNOOZE)) begin
            st_d   = SNOOZED;
            cd_d   = CW'(SNZ_LOAD);
            snz_d  = snz_q + 3'd1;
            ring_d = '0;
          end else begin
            clr = 1'b1;
          end
        end else if (dis) begin
          clr = 1'b1;
        end else if (tick_i) begin
          if (ring_q == RW'(RING_SEC - 1)) clr = 1'b1;
          else                             ring_d = ring_q + 1'b1;
        end
      end
      SNOOZED: begin
        if (stop_i || dis) begin
          clr = 1'b1;
        end else if (tick_i) begin
          if (cd_q == CW'(1)) begin
            st_d   = RINGING;
            ring_d = '0;
            cd_d   = '0;
          end else begin
            cd_d = cd_q - 1'b1;
          end
        end
      end
      default: clr = 1'b1;
    endcase
    if (clr) begin
      st_d   = IDLE;
      ring_d = '0;
      cd_d   = '0;
      snz_d  = '0;
    end
  end

  // Channel state registers
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      hr_q   <= 8'h00;
      mn_q   <= 8'h00;
      en_q   <= 1'b0;
      st_q   <= IDLE;
      ring_q <= '0;
      cd_q   <= '0;
      snz_q  <= '0;
    end else begin
      hr_q   <= hr_d;
      mn_q   <= mn_d;
      en_q   <= en_d;
      st_q   <= st_d;
      ring_q <= ring_d;
      cd_q   <= cd_d;
      snz_q  <= snz_d;
    end
  end

  assign rsp_o = '{hr: hr_q, mn: mn_q, en: en_q, ring: (st_q == RINGING)};
endmodule

// Bank top: channel select/decode, readback registers and tone gating
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter  int N_ALARMS   = 4,
  parameter  int SNOOZE_MIN = 5,
  parameter  int RING_SEC   = 60,
  parameter  int MAX_SNOOZE = 3,
  localparam int SEL_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                CP,
  input  logic                nCR,
  input  logic                Tick1s,
  input  logic [7:0]          Hour,
  input  logic [7:0]          Minute,
  input  logic [7:0]          Second,
  input  logic [SEL_W-1:0]    Sel,
  input  logic                SetHrkey,
  input  logic                SetMinkey,
  input  logic                EnKey,
  input  logic                SnoozeKey,
  input  logic                StopKey,
  input  logic                CtrlBell,
  input  logic                _2Hz,
  input  logic                _500Hz,
  output logic [7:0]          Set_Hr,
  output logic [7:0]          Set_Min,
  output logic [N_ALARMS-1:0] AlarmEn,
  output logic [N_ALARMS-1:0] Ringing,
  output logic                ALARM_Clock
);
  logic      [N_ALARMS-1:0] hit;
  set_req_t  [N_ALARMS-1:0] req;
  chan_rsp_t [N_ALARMS-1:0] rsp;
  logic [7:0] set_hr_q, set_hr_d, set_min_q, set_min_d;

  // Select decode; an out-of-range Sel hits nothing, so keys drop and readback is 00
  always_comb begin
    set_hr_d  = 8'h00;
    set_min_d = 8'h00;
    for (int i = 0; i < N_ALARMS; i++) begin
      hit[i]     = (Sel == SEL_W'(i));
      req[i]     = '{set_hr: SetHrkey & hit[i], set_min: SetMinkey & hit[i], en: EnKey & hit[i]};
      AlarmEn[i] = rsp[i].en;
      Ringing[i] = rsp[i].ring;
      if (hit[i]) begin
        set_hr_d  = set_hr_d  | rsp[i].hr;
        set_min_d = set_min_d | rsp[i].mn;
      end
    end
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
    alarm_chan #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SEC   (RING_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_chan (
      .CP       (CP),
      .nCR      (nCR),
      .req_i    (req[g]),
      .snooze_i (SnoozeKey),
      .stop_i   (StopKey),
      .tick_i   (Tick1s),
      .hour_i   (Hour),
      .minute_i (Minute),
      .second_i (Second),
      .rsp_o    (rsp[g])
    );
  end

  // Registered readback of the selected channel's alarm time
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      set_hr_q  <= 8'h00;
      set_min_q <= 8'h00;
    end else begin
      set_hr_q  <= set_hr_d;
      set_min_q <= set_min_d;
    end
  end

  assign Set_Hr  = set_hr_q;
  assign Set_Min = set_min_q;

  // Tone is gated only; muting never stalls the channel FSMs
  assign ALARM_Clock = CtrlBell & (|Ringing) & (Second[0] ? _2Hz : _500Hz);
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm block replacing the single-alarm bell in the clock-calendar top level. Holds N independent BCD alarm times with per-channel enable, detects each match once at the minute boundary, and runs a per-channel ring/snooze/auto-stop state machine. It drives one gated tone output from the existing `_2Hz` and `_500Hz` tone levels. Everything runs on one system clock, with a one-cycle second tick from the timekeeper.

## Interface
- `N_ALARMS`, 4: number of alarm channels (1..8).
- `SNOOZE_MIN`, 5: snooze length in minutes (1..30).
- `RING_SEC`, 60: auto-stop after this many seconds of ringing (1..255).
- `MAX_SNOOZE`, 3: snoozes allowed per trigger (0..7).
- `SEL_W`: derived as max(1, clog2(N_ALARMS)); not user-set.

Ports:
- `CP`  in  1  system clock, rising edge.
- `nCR`  in  1  reset, asynchronous, active-low.
- `Tick1s`  in  1  one-CP pulse per second. `Hour`, `Minute` and `Second` already hold the new time while it is high.
- `Hour`, `Minute`, `Second`  in  8 each  current time, BCD.
- `Sel`  in  SEL_W  channel addressed by the set and enable keys.
- `SetHrkey`, `SetMinkey`, `EnKey`  in  1 each  one-CP debounced key pulses.
- `SnoozeKey`, `StopKey`  in  1 each  one-CP debounced key pulses.
- `CtrlBell`  in  1  global sound enable (level).
- `_2Hz`, `_500Hz`  in  1 each  tone levels, sampled as data, not clocks.
- `Set_Hr`, `Set_Min`  out  8 each  BCD alarm time of channel `Sel`.
- `AlarmEn`  out  N_ALARMS  per-channel enable.
- `Ringing`  out  N_ALARMS  per-channel RINGING state.
- `ALARM_Clock`  out  1  tone output.

## Operation
- **Reset (`nCR` = 0)**
  - All alarm times 00:00, `AlarmEn` = 0, all channels IDLE, `Ringing` = 0, all counters 0, `ALARM_Clock` = 0.
  - Reset asserted mid-ring or mid-snooze aborts it immediately.
- **Setting (channel `Sel`)**
  - `SetMinkey` increments minutes BCD 00..59, wrapping 59→00, with no carry into hours.
  - `SetHrkey` increments hours BCD 00..23, wrapping 23→00.
  - `EnKey` toggles the enable. Disabling forces that channel to IDLE and clears its counters.
  - Setting never disturbs a ring already in progress.
- **Out-of-range select**: with `Sel` ≥ N_ALARMS, all three keys are ignored and `Set_Hr`/`Set_Min` read 8'h00.
- **Per-channel states**: IDLE, RINGING, SNOOZED.
- **IDLE→RINGING** on a cycle where all of these hold:
  - `Tick1s` = 1 and `Second` = 8'h00;
  - the channel is enabled;
  - `Hour`:`Minute` equals the channel's alarm time.
  - Entry clears the ring counter and the snooze count. Each match fires once per day.
- **RINGING**
  - Ring counter increments on each `Tick1s`.
  - A `Tick1s` arriving with count = RING_SEC−1 moves the channel to IDLE (auto-stop).
- **SnoozeKey**: applies to every RINGING channel.
  - If snooze count < MAX_SNOOZE: go to SNOOZED, load the countdown with SNOOZE_MIN×60, increment the snooze count.
  - Otherwise: go to IDLE.
- **SNOOZED**
  - Countdown decrements on each `Tick1s`.
  - A `Tick1s` arriving with countdown = 1 moves the channel to RINGING and clears the ring counter. The snooze count is retained.
- **StopKey**: every RINGING or SNOOZED channel goes to IDLE and clears its counters.
- **Priority within one cycle, per channel**: reset > StopKey > SnoozeKey > disable by EnKey > tick-driven transitions (timeout, snooze expiry).
  - A channel that is IDLE at the start of the cycle still evaluates its trigger even when StopKey or SnoozeKey is high.
  - The channel's own EnKey disable suppresses that trigger.
- **Tone**: `ALARM_Clock` = `CtrlBell` & (|`Ringing`) & (`Second[0]` ? `_2Hz` : `_500Hz`).
  - `CtrlBell` mutes the output only. State machines keep running while muted.

## Timing
- All state, `Set_Hr`, `Set_Min`, `AlarmEn` and `Ringing` are registered on `CP`. A key or tick takes effect on the next rising edge.
- `ALARM_Clock` is combinational from registered `Ringing` and the live `CtrlBell`, `Second[0]`, `_2Hz` and `_500Hz` inputs.
- Trigger latency: `Ringing[i]` is high in the cycle after the matching `Tick1s`.
- Ring duration: exactly RING_SEC `Tick1s` pulses, counted from entry.
- Snooze: `Ringing[i]` returns one cycle after the SNOOZE_MIN×60-th `Tick1s` following the snooze press.
- Counter widths:
  - ring counter clog2(RING_SEC+1) bits;
  - countdown clog2(SNOOZE_MIN×60+1) bits;
  - snooze count 3 bits.
  - No counter wraps. Each is bounded by its state transition.

## Test plan
- **Reset then set**: after reset, with `Sel`=1, pulse `SetHrkey`×7 and `SetMinkey`×30, enable with `EnKey`.
  - Required: `Set_Hr`=8'h07, `Set_Min`=8'h30, `AlarmEn`=4'b0010, `Ringing`=0.
- **Wrap**: pulse `SetMinkey`×60 and `SetHrkey`×24 from 00:00.
  - Required: reads back 00:00; hour unchanged by the minute wrap.
- **Trigger and auto-stop**: drive time 07:30:00 with `Tick1s`.
  - Required: `Ringing`=4'b0010 next cycle; `ALARM_Clock` follows `_500Hz` when `Second` is even and `_2Hz` when odd; `Ringing` clears after 60 ticks.
  - Also check that 07:30:01 with `Tick1s` does not re-trigger.
- **Snooze limit**: trigger, then press `SnoozeKey` 3 times, each after re-ring.
  - Required: re-ring 300 ticks after each press; the 4th press goes to IDLE.
  - Also check that `CtrlBell`=0 gives `ALARM_Clock`=0 while `Ringing`≠0.
- **Simultaneous events**:
  - Channel 0 ringing and channel 2 matching in the same cycle as `StopKey`: channel 0 goes IDLE and channel 2 goes RINGING.
  - `StopKey` and `SnoozeKey` together: channel goes IDLE.
  - `nCR` pulsed during SNOOZED: all outputs return to their reset values asynchronously.
